// File: rtl/dac_lvds_tx_pkg.sv
// dac_lvds_tx_pkg: link state encoding and default lane words for the DAC LVDS transmitter
package dac_lvds_tx_pkg;
  typedef enum logic [1:0] {IDLE, TRAIN, SYNC, STREAM} tx_state_t;
  localparam logic [47:0] DEF_TRAIN_WORD = 48'hAAAA_AAAA_AAAA;
  localparam logic [47:0] DEF_SYNC_WORD = 48'hF0F0_0F0F_FF00;
  localparam int UNDERFLOW_W = 16;
endpackage

// File: rtl/dac_lvds_tx_if.sv
// dac_lvds_tx_if: valid/ready sample source feeding the transmitter
interface dac_lvds_tx_if #(parameter int LANES = 48);
  logic s_valid;
  logic [LANES-1:0] s_data;
  logic s_ready;
  modport master(output s_valid, s_data, input s_ready);
  modport slave(input s_valid, s_data, output s_ready);
endinterface

// File: rtl/dac_lvds_tx.sv
// dac_lvds_tx: link bring-up (training, sync) then sample streaming onto registered LVDS lanes
module dac_lvds_tx
  import dac_lvds_tx_pkg::*;
#(
  parameter int LANES = 48,
  parameter logic [LANES-1:0] TRAIN_WORD = LANES'(DEF_TRAIN_WORD),
  parameter int TRAIN_LEN = 64,
  parameter logic [LANES-1:0] SYNC_WORD = LANES'(DEF_SYNC_WORD),
  parameter int FRAME_LEN = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic train_req,
  dac_lvds_tx_if.slave s,
  output logic [LANES-1:0] tx_data,
  output logic tx_frame,
  output logic link_up,
  output logic [UNDERFLOW_W-1:0] underflow_cnt
);
  localparam int TW = $clog2(TRAIN_LEN);
  localparam int FW = $clog2(FRAME_LEN);
  tx_state_t state, state_nxt;
  logic [TW-1:0] train_cnt, train_cnt_nxt;
  logic [FW-1:0] frame_cnt, frame_cnt_nxt;
  logic [LANES-1:0] data_nxt;
  logic frame_nxt;
  logic [UNDERFLOW_W-1:0] uf_nxt;
  assign s.s_ready = state == STREAM && enable && !train_req;
  // Lane outputs are computed from the current state and land on the next edge.
  always_comb begin
    state_nxt = state;
    train_cnt_nxt = train_cnt;
    frame_cnt_nxt = frame_cnt;
    data_nxt = tx_data;
    frame_nxt = 1'b0;
    uf_nxt = underflow_cnt;
    if (!enable) begin
      state_nxt = IDLE;
      data_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = TRAIN;
          train_cnt_nxt = '0;
          data_nxt = '0;
        end
        TRAIN: begin
          data_nxt = train_cnt[0] ? ~TRAIN_WORD : TRAIN_WORD;
          frame_nxt = train_cnt[0];
          train_cnt_nxt = train_cnt + 1'b1;
          state_nxt = train_cnt == TW'(TRAIN_LEN - 1) ? SYNC : TRAIN;
        end
        SYNC: begin
          data_nxt = SYNC_WORD;
          frame_nxt = 1'b1;
          frame_cnt_nxt = '0;
          state_nxt = STREAM;
        end
        default: begin
          if (train_req) begin
            state_nxt = TRAIN;
            train_cnt_nxt = '0;
          end else begin
            frame_nxt = frame_cnt == '0;
            frame_cnt_nxt = frame_cnt + 1'b1;
            data_nxt = s.s_valid ? s.s_data : tx_data;
            uf_nxt = s.s_valid || &underflow_cnt ? underflow_cnt : underflow_cnt + 1'b1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      train_cnt <= '0;
      frame_cnt <= '0;
      tx_data <= '0;
      tx_frame <= 1'b0;
      link_up <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      state <= state_nxt;
      train_cnt <= train_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      tx_data <= data_nxt;
      tx_frame <= frame_nxt;
      link_up <= state_nxt == STREAM;
      underflow_cnt <= uf_nxt;
    end
  end
endmodule

// File: tb/tb_dac_lvds_tx.sv
// tb_dac_lvds_tx: randomized stimulus, phase-level reference model and queued scoreboard for dac_lvds_tx
module tb_dac_lvds_tx;
  localparam logic [47:0] TWORD = 48'hAAAA_AAAA_AAAA;
  localparam logic [47:0] SWORD = 48'hF0F0_0F0F_FF00;
  typedef struct {
    logic ready;
    logic [47:0] data;
    logic frame;
    logic link;
    logic [15:0] uf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic train_req = 1'b0;
  logic [47:0] tx_data;
  logic tx_frame;
  logic link_up;
  logic [15:0] underflow_cnt;
  exp_t q[$];
  exp_t cur;
  int total = 0;
  int bad = 0;
  int phase = 0;
  int k = 0;
  int fpos = 0;
  int uf = 0;
  logic [47:0] md = '0;
  logic mf = 1'b0;
  logic [47:0] cnt = 48'h1;
  dac_lvds_tx_if #(.LANES(48)) sif();
  dac_lvds_tx dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .train_req(train_req),
    .s(sif),
    .tx_data(tx_data),
    .tx_frame(tx_frame),
    .link_up(link_up),
    .underflow_cnt(underflow_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [47:0] rnd();
    return 48'({$urandom(), $urandom()});
  endfunction
  function automatic void chk(string n, logic [47:0] a, logic [47:0] e);
    total++;
    if (a !== e) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h want %h", n, a, e);
    end
  endfunction
  // phase 0 idle, 1 training (k = word index), 2 sync, 3 streaming (fpos = position in frame)
  task automatic cyc(input logic r, input logic e, input logic t, input logic v, input logic [47:0] d);
    exp_t x;
    @(negedge clk);
    rst = r;
    enable = e;
    train_req = t;
    sif.s_valid = v;
    sif.s_data = d;
    x.ready = phase == 3 && e && !t;
    if (r) begin
      phase = 0;
      md = '0;
      mf = 1'b0;
      uf = 0;
    end else if (!e) begin
      phase = 0;
      md = '0;
      mf = 1'b0;
    end else if (phase == 0) begin
      phase = 1;
      k = 0;
      md = '0;
      mf = 1'b0;
    end else if (phase == 1) begin
      md = (k % 2 == 1) ? ~TWORD : TWORD;
      mf = k % 2 == 1;
      k++;
      if (k == 64) phase = 2;
    end else if (phase == 2) begin
      md = SWORD;
      mf = 1'b1;
      fpos = 0;
      phase = 3;
    end else if (t) begin
      mf = 1'b0;
      phase = 1;
      k = 0;
    end else begin
      mf = fpos == 0;
      fpos = (fpos + 1) % 1024;
      if (v) md = d;
      else if (uf < 65535) uf++;
    end
    x.data = md;
    x.frame = mf;
    x.link = phase == 3;
    x.uf = 16'(uf);
    q.push_back(x);
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      cur = q.pop_front();
      chk("s_ready", 48'(sif.s_ready), 48'(cur.ready));
      @(posedge clk);
      #1;
      chk("tx_data", tx_data, cur.data);
      chk("tx_frame", 48'(tx_frame), 48'(cur.frame));
      chk("link_up", 48'(link_up), 48'(cur.link));
      chk("underflow_cnt", 48'(underflow_cnt), 48'(cur.uf));
    end
  end
  initial begin
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    @(posedge clk);
    repeat (3) cyc(1, 0, 0, 0, '0);
    repeat (5) cyc(0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)), rnd());
    for (int i = 0; i < 70; i++) cyc(0, 1, i < 60 ? 1'($urandom_range(1)) : 1'b0, 1'($urandom_range(1)), rnd());
    for (int i = 0; i < 2100; i++) begin
      cyc(0, 1, 0, !(i >= 1000 && i < 1005), cnt);
      cnt++;
    end
    cyc(0, 1, 1, 1, rnd());
    repeat (70) cyc(0, 1, 0, 1'($urandom_range(1)), rnd());
    repeat (70000) cyc(0, 1, 0, 0, rnd());
    repeat (20) cyc(0, 1, 0, 1, rnd());
    cyc(0, 0, 1, 1, rnd());
    repeat (3) cyc(0, 0, 0, 1, rnd());
    repeat (30) cyc(0, 1, 0, 1, rnd());
    cyc(1, 1, 0, 1, rnd());
    repeat (3) cyc(0, 1, 0, 1, rnd());
    repeat (600) cyc(0, $urandom_range(99) != 0, $urandom_range(49) == 0, 1'($urandom_range(1)), rnd());
    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
